// File: rtl/const_pkg.sv
// Shared constants, state encoding and response helpers for the AXI-Lite to MMIO slot bridge.
package const_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned REG_ADDR_W = 8;
    localparam int unsigned TMO_CNT_W  = 16;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_ADDR   = 3'd1,
        ST_WR_DATA   = 3'd2,
        ST_WR_ACCESS = 3'd3,
        ST_WR_RESP   = 3'd4,
        ST_RD_ACCESS = 3'd5,
        ST_RD_RESP   = 3'd6
    } axi_mmio_bridge_state_t;

    // Slave error outranks decode error; neither means OKAY.
    function automatic logic [1:0] resp_sel(input logic slv_err, input logic dec_err);
        if (slv_err) begin
            return AXI_RESP_SLVERR;
        end
        if (dec_err) begin
            return AXI_RESP_DECERR;
        end
        return AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/mmio_timeout_counter.sv
// Saturating access-cycle counter; expired_o flags the last allowed cycle of a slot access.
module mmio_timeout_counter
    import const_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q < LAST)) begin
            cnt_q <= cnt_q + TMO_CNT_W'(1);
        end
    end

    // Access cycle N sees cnt_q == N-1, so this fires on cycle LIMIT.
    assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/axi_mmio_bridge.sv
// AXI4-Lite slave that decodes a 64 KiB window into NUM_SLOTS MMIO slots with done/error handshakes.
module axi_mmio_bridge
    import const_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 16,
    parameter logic [15:0] BASE_HI   = 16'h4600,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                                 aclk,
    input  logic                                 arst,
    input  logic [AXI_ADDR_W-1:0]                S_AXI_awaddr,
    input  logic [2:0]                           S_AXI_awprot,
    input  logic                                 S_AXI_awvalid,
    output logic                                 S_AXI_awready,
    input  logic [AXI_DATA_W-1:0]                S_AXI_wdata,
    input  logic [AXI_STRB_W-1:0]                S_AXI_wstrb,
    input  logic                                 S_AXI_wvalid,
    output logic                                 S_AXI_wready,
    output logic [1:0]                           S_AXI_bresp,
    output logic                                 S_AXI_bvalid,
    input  logic                                 S_AXI_bready,
    input  logic [AXI_ADDR_W-1:0]                S_AXI_araddr,
    input  logic [2:0]                           S_AXI_arprot,
    input  logic                                 S_AXI_arvalid,
    output logic                                 S_AXI_arready,
    output logic [AXI_DATA_W-1:0]                S_AXI_rdata,
    output logic [1:0]                           S_AXI_rresp,
    output logic                                 S_AXI_rvalid,
    input  logic                                 S_AXI_rready,
    output logic [NUM_SLOTS-1:0]                 slot_chip_select,
    output logic                                 read,
    output logic                                 write,
    output logic [REG_ADDR_W-1:0]                reg_addr,
    output logic [AXI_DATA_W-1:0]                slot_wr_data,
    output logic [AXI_STRB_W-1:0]                slot_wr_strb,
    input  logic [NUM_SLOTS-1:0][AXI_DATA_W-1:0] slot_rd_data,
    input  logic [NUM_SLOTS-1:0]                 slot_wr_done,
    input  logic [NUM_SLOTS-1:0]                 slot_rd_done,
    input  logic [NUM_SLOTS-1:0]                 slot_slave_error,
    input  logic [NUM_SLOTS-1:0]                 slot_decode_error,
    output logic                                 transaction_completed
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [NUM_SLOTS-1:0] CS_ONE = NUM_SLOTS'(1);

    axi_mmio_bridge_state_t state_q;

    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic [AXI_STRB_W-1:0] wstrb_q;
    logic [AXI_DATA_W-1:0] rdata_q;
    logic [1:0]            bresp_q;
    logic [1:0]            rresp_q;
    logic                  bvalid_q;
    logic                  rvalid_q;
    logic                  read_q;
    logic                  write_q;
    logic [NUM_SLOTS-1:0]  cs_q;
    logic                  rr_q;

    logic                  awready_c, wready_c, arready_c, rd_win_c;
    logic                  aw_hs_c, w_hs_c, ar_hs_c, wr_launch_c;
    logic [AXI_ADDR_W-1:0] wr_addr_c;
    logic [AXI_DATA_W-1:0] wr_data_c;
    logic [AXI_STRB_W-1:0] wr_strb_c;
    logic [SLOT_W-1:0]     slot_c;
    logic                  in_access_c, tmo_expired_c;

    function automatic logic in_range(input logic [AXI_ADDR_W-1:0] a);
        return (a[31:16] == BASE_HI) && (32'(a[15:8]) < NUM_SLOTS);
    endfunction

    // Channel readies; the loser of an AW/AR tie sees ready low, and W is
    // held off while a read is being granted so no write data is stranded.
    always_comb begin
        awready_c = 1'b0;
        wready_c  = 1'b0;
        arready_c = 1'b0;
        rd_win_c  = S_AXI_arvalid && (!S_AXI_awvalid || rr_q);
        if (!arst) begin
            case (state_q)
                ST_IDLE: begin
                    awready_c = !(S_AXI_arvalid && S_AXI_awvalid && rr_q);
                    arready_c = !(S_AXI_arvalid && S_AXI_awvalid && !rr_q);
                    wready_c  = !rd_win_c;
                end
                ST_WR_ADDR: awready_c = 1'b1;
                ST_WR_DATA: wready_c  = 1'b1;
                default: ;
            endcase
        end
    end

    assign aw_hs_c = S_AXI_awvalid && awready_c;
    assign w_hs_c  = S_AXI_wvalid  && wready_c;
    assign ar_hs_c = S_AXI_arvalid && arready_c;

    assign wr_addr_c   = (state_q == ST_WR_DATA) ? addr_q  : S_AXI_awaddr;
    assign wr_data_c   = (state_q == ST_WR_ADDR) ? wdata_q : S_AXI_wdata;
    assign wr_strb_c   = (state_q == ST_WR_ADDR) ? wstrb_q : S_AXI_wstrb;
    assign wr_launch_c = ((state_q == ST_IDLE)    && aw_hs_c && w_hs_c) ||
                         ((state_q == ST_WR_ADDR) && aw_hs_c) ||
                         ((state_q == ST_WR_DATA) && w_hs_c);

    assign slot_c      = addr_q[8 +: SLOT_W];
    assign in_access_c = (state_q == ST_WR_ACCESS) || (state_q == ST_RD_ACCESS);

    mmio_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk_i     (aclk),
        .rst_i     (arst),
        .clear_i   (!in_access_c),
        .en_i      (in_access_c),
        .expired_o (tmo_expired_c)
    );

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            bresp_q  <= AXI_RESP_OKAY;
            rresp_q  <= AXI_RESP_OKAY;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            cs_q     <= '0;
            rr_q     <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && (ar_hs_c || aw_hs_c || w_hs_c)) begin
                rr_q <= !rr_q;
            end
            case (state_q)
                ST_IDLE, ST_WR_ADDR, ST_WR_DATA: begin
                    if (ar_hs_c) begin
                        addr_q <= S_AXI_araddr;
                        if (in_range(S_AXI_araddr)) begin
                            cs_q    <= CS_ONE << S_AXI_araddr[8 +: SLOT_W];
                            read_q  <= 1'b1;
                            state_q <= ST_RD_ACCESS;
                        end else begin
                            rdata_q  <= '0;
                            rresp_q  <= AXI_RESP_DECERR;
                            rvalid_q <= 1'b1;
                            state_q  <= ST_RD_RESP;
                        end
                    end else if (wr_launch_c) begin
                        addr_q  <= wr_addr_c;
                        wdata_q <= wr_data_c;
                        wstrb_q <= wr_strb_c;
                        if (in_range(wr_addr_c)) begin
                            cs_q    <= CS_ONE << wr_addr_c[8 +: SLOT_W];
                            write_q <= 1'b1;
                            state_q <= ST_WR_ACCESS;
                        end else begin
                            bresp_q  <= AXI_RESP_DECERR;
                            bvalid_q <= 1'b1;
                            state_q  <= ST_WR_RESP;
                        end
                    end else if (aw_hs_c) begin
                        addr_q  <= S_AXI_awaddr;
                        state_q <= ST_WR_DATA;
                    end else if (w_hs_c) begin
                        wdata_q <= S_AXI_wdata;
                        wstrb_q <= S_AXI_wstrb;
                        state_q <= ST_WR_ADDR;
                    end
                end
                ST_WR_ACCESS: begin
                    if (slot_wr_done[slot_c] || tmo_expired_c) begin
                        bresp_q  <= slot_wr_done[slot_c]
                                    ? resp_sel(slot_slave_error[slot_c], slot_decode_error[slot_c])
                                    : AXI_RESP_SLVERR;
                        bvalid_q <= 1'b1;
                        cs_q     <= '0;
                        write_q  <= 1'b0;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_RD_ACCESS: begin
                    if (slot_rd_done[slot_c]) begin
                        rdata_q <= slot_rd_data[slot_c];
                        rresp_q <= resp_sel(slot_slave_error[slot_c], slot_decode_error[slot_c]);
                    end else begin
                        rdata_q <= '0;
                        rresp_q <= AXI_RESP_SLVERR;
                    end
                    if (slot_rd_done[slot_c] || tmo_expired_c) begin
                        rvalid_q <= 1'b1;
                        cs_q     <= '0;
                        read_q   <= 1'b0;
                        state_q  <= ST_RD_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (S_AXI_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RD_RESP: begin
                    if (S_AXI_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign S_AXI_awready         = awready_c;
    assign S_AXI_wready          = wready_c;
    assign S_AXI_arready         = arready_c;
    assign S_AXI_bresp           = bresp_q;
    assign S_AXI_bvalid          = bvalid_q;
    assign S_AXI_rdata           = rdata_q;
    assign S_AXI_rresp           = rresp_q;
    assign S_AXI_rvalid          = rvalid_q;
    assign slot_chip_select      = cs_q;
    assign read                  = read_q;
    assign write                 = write_q;
    assign reg_addr              = addr_q[REG_ADDR_W-1:0];
    assign slot_wr_data          = wdata_q;
    assign slot_wr_strb          = wstrb_q;
    assign transaction_completed = (bvalid_q && S_AXI_bready) || (rvalid_q && S_AXI_rready);

    logic unused_c;
    assign unused_c = ^{S_AXI_awprot, S_AXI_arprot, addr_q};

endmodule

// File: tb/tb_axi_mmio_bridge.sv
// Directed self-checking bench for axi_mmio_bridge (NUM_SLOTS=16, TIMEOUT=8).
module tb_axi_mmio_bridge;

    localparam int unsigned NS = 16;

    logic              aclk = 1'b0;
    logic              arst;
    logic [31:0]       awaddr, wdata, araddr, rdata;
    logic [2:0]        awprot, arprot;
    logic [3:0]        wstrb, slot_wr_strb;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [1:0]        bresp, rresp;
    logic [NS-1:0]     cs;
    logic              rd, wr, tc;
    logic [7:0]        reg_addr;
    logic [31:0]       slot_wr_data;
    logic [NS-1:0][31:0] slot_rd_data;
    logic [NS-1:0]     wr_done, rd_done, slv_err, dec_err;

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    axi_mmio_bridge #(
        .NUM_SLOTS (NS),
        .BASE_HI   (16'h4600),
        .TIMEOUT   (8)
    ) dut (
        .aclk                  (aclk),
        .arst                  (arst),
        .S_AXI_awaddr          (awaddr),
        .S_AXI_awprot          (awprot),
        .S_AXI_awvalid         (awvalid),
        .S_AXI_awready         (awready),
        .S_AXI_wdata           (wdata),
        .S_AXI_wstrb           (wstrb),
        .S_AXI_wvalid          (wvalid),
        .S_AXI_wready          (wready),
        .S_AXI_bresp           (bresp),
        .S_AXI_bvalid          (bvalid),
        .S_AXI_bready          (bready),
        .S_AXI_araddr          (araddr),
        .S_AXI_arprot          (arprot),
        .S_AXI_arvalid         (arvalid),
        .S_AXI_arready         (arready),
        .S_AXI_rdata           (rdata),
        .S_AXI_rresp           (rresp),
        .S_AXI_rvalid          (rvalid),
        .S_AXI_rready          (rready),
        .slot_chip_select      (cs),
        .read                  (rd),
        .write                 (wr),
        .reg_addr              (reg_addr),
        .slot_wr_data          (slot_wr_data),
        .slot_wr_strb          (slot_wr_strb),
        .slot_rd_data          (slot_rd_data),
        .slot_wr_done          (wr_done),
        .slot_rd_done          (rd_done),
        .slot_slave_error      (slv_err),
        .slot_decode_error     (dec_err),
        .transaction_completed (tc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int n;
        int bad;
        arst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        wr_done = '0; rd_done = '0; slv_err = '0; dec_err = '0;
        for (int i = 0; i < NS; i++) slot_rd_data[i] = 32'hA000_0000 | 32'(i);

        // Reset state
        tick(); tick(); tick();
        chk("rst_readys", 64'({awready, wready, arready}), 64'h0);
        chk("rst_outs", 64'({bvalid, rvalid, cs, rd, wr, tc}), 64'h0);
        arst = 1'b0;
        #1;
        chk("idle_readys", 64'({awready, wready, arready}), 64'h7);

        // Write 0x4600_0304, slot3 done on third access cycle
        awaddr = 32'h4600_0304; awvalid = 1'b1;
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("w1_cs", 64'(cs), 64'h0008);
        chk("w1_strobes", 64'({wr, rd, reg_addr}), 64'h2_04);
        chk("w1_data", 64'({slot_wr_data, slot_wr_strb}), 64'hDEADBEEF_F);
        tick(); tick();
        wr_done[3] = 1'b1;
        tick();
        wr_done[3] = 1'b0;
        chk("w1_resp", 64'({bvalid, bresp, cs, wr}), 64'({1'b1, 2'b00, 16'h0, 1'b0}));
        tick();
        chk("w1_bvalid_hold", 64'({bvalid, bresp}), 64'h4);
        bready = 1'b1;
        #1;
        chk("w1_tc", 64'(tc), 64'h1);
        tick();
        chk("w1_done", 64'({bvalid, tc}), 64'h0);
        bready = 1'b0;

        // W two cycles before AW
        wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("w2_wait_aw", 64'({awready, wready, wr}), 64'h4);
        tick();
        awaddr = 32'h4600_0100; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("w2_access", 64'({cs, wr, reg_addr, slot_wr_strb}), 64'({16'h0002, 1'b1, 8'h00, 4'h3}));
        chk("w2_data", 64'(slot_wr_data), 64'h1234_5678);
        wr_done[1] = 1'b1;
        tick();
        wr_done[1] = 1'b0;
        chk("w2_resp", 64'({bvalid, bresp, wr}), 64'h8);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Out-of-range write
        awaddr = 32'h4700_0000; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("w_oor", 64'({bvalid, bresp, cs, wr}), 64'({1'b1, 2'b11, 16'h0, 1'b0}));
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Read slot5 with decode error
        araddr = 32'h4600_0510; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("r_dec_access", 64'({cs, rd, wr, reg_addr}), 64'({16'h0020, 1'b1, 1'b0, 8'h10}));
        rd_done[5] = 1'b1; dec_err[5] = 1'b1;
        tick();
        rd_done[5] = 1'b0; dec_err[5] = 1'b0;
        chk("r_dec_resp", 64'({rvalid, rresp, rdata}), 64'({1'b1, 2'b11, 32'hA000_0005}));
        rready = 1'b1;
        tick();
        rready = 1'b0;

        // Out-of-range read 0x4600_1F00
        araddr = 32'h4600_1F00; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("r_oor", 64'({rvalid, rresp, rdata, cs, rd}), 64'({1'b1, 2'b11, 32'h0, 16'h0, 1'b0}));
        rready = 1'b1;
        #1;
        chk("r_oor_tc", 64'(tc), 64'h1);
        tick();
        rready = 1'b0;

        // Read slot2 that never completes
        araddr = 32'h4600_0200; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("r_tmo_access", 64'({cs, rd}), 64'({16'h0004, 1'b1}));
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("r_tmo_cycles", 64'(n), 64'd8);
        chk("r_tmo_resp", 64'({rresp, rdata, cs, rd}), 64'({2'b10, 32'h0, 16'h0, 1'b0}));
        rready = 1'b1;
        tick();
        rready = 1'b0;

        // Reset during a write access
        awaddr = 32'h4600_0408; wdata = 32'h5555_AAAA; wstrb = 4'hC;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("rst_mid_access", 64'({cs, wr}), 64'({16'h0010, 1'b1}));
        arst = 1'b1;
        tick();
        chk("rst_mid_ctl", 64'({cs, wr, rd, bvalid, rvalid, awready, wready, arready, tc, reg_addr, bresp, rresp}), 64'h0);
        chk("rst_mid_data", 64'({slot_wr_data, rdata}), 64'h0);
        chk("rst_mid_strb", 64'(slot_wr_strb), 64'h0);
        arst = 1'b0;
        wr_done[4] = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bvalid) bad++;
        end
        wr_done[4] = 1'b0;
        chk("rst_no_bvalid", 64'(bad), 64'h0);

        // AW/AR contention twice: write first, then read
        awaddr = 32'h4600_0600; awvalid = 1'b1;
        wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h4600_0700; arvalid = 1'b1;
        #1;
        chk("arb1_readys", 64'({awready, wready, arready}), 64'h6);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("arb1_write", 64'({cs, wr, rd}), 64'({16'h0040, 1'b1, 1'b0}));
        wr_done[6] = 1'b1; slv_err[6] = 1'b1; dec_err[6] = 1'b1;
        tick();
        wr_done[6] = 1'b0; slv_err[6] = 1'b0; dec_err[6] = 1'b0;
        chk("arb1_resp", 64'({bvalid, bresp}), 64'h6);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("arb2_readys", 64'({awready, wready, arready}), 64'h1);
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("arb2_read", 64'({cs, rd, wr, reg_addr}), 64'({16'h0080, 1'b1, 1'b0, 8'h00}));
        rd_done[7] = 1'b1;
        tick();
        rd_done[7] = 1'b0;
        slot_rd_data[7] = 32'h0BAD_F00D;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!rvalid || rdata !== 32'hA000_0007 || rresp !== 2'b00) bad++;
            tick();
        end
        chk("arb2_rstable", 64'(bad), 64'h0);
        rready = 1'b1;
        #1;
        chk("arb2_tc", 64'({tc, rdata}), 64'({1'b1, 32'hA000_0007}));
        tick();
        rready = 1'b0;
        chk("arb2_idle", 64'({rvalid, tc, awready, arready}), 64'h3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
